// File: rtl/div_sequencer.sv
// div_sequencer: drives one 64-bit iterative unsigned Divider on behalf of
// RISC-V M-extension DIV/DIVU/REM/REMU and their W forms.
//   clk, reset                   clock, asynchronous active-high reset
//   req_valid/req_ready          request handshake (ready only when idle)
//   req_op, req_word             op {rem, unsigned}, 32-bit W form
//   req_a, req_b                 dividend, divisor
//   flush                        drop any in-flight request
//   resp_valid/resp_ready        response handshake, resp_data held until taken
//   div_en                       one-cycle start pulse to the Divider
//   div_dividend, div_divisor    operand magnitudes, held while it iterates
//   div_quotient, div_remainder  Divider results
//   div_compl                    Divider completion flag
module div_sequencer #(
   parameter int unsigned XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [1:0]      req_op,
   input  logic            req_word,
   input  logic [XLEN-1:0] req_a,
   input  logic [XLEN-1:0] req_b,
   input  logic            flush,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_data,
   output logic            div_en,
   output logic [XLEN-1:0] div_dividend,
   output logic [XLEN-1:0] div_divisor,
   input  logic [XLEN-1:0] div_quotient,
   input  logic [XLEN-1:0] div_remainder,
   input  logic            div_compl
);

   localparam int unsigned HALF = XLEN / 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t state;

   // Latched request attributes used by the result fix-up
   logic op_rem;
   logic op_word;
   logic neg_a;
   logic neg_b;

   // Sign-extend the low half of a word to full width
   function automatic logic [XLEN-1:0] sext_half(input logic [XLEN-1:0] v);
      return {{HALF{v[HALF-1]}}, v[HALF-1:0]};
   endfunction

   // Two's-complement negate; the most negative value maps to itself
   function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] v);
      return XLEN'(0) - v;
   endfunction

   // Operand preparation and special-case detection for the incoming request
   logic            in_signed;
   logic [XLEN-1:0] a_prep;
   logic [XLEN-1:0] b_prep;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic [XLEN-1:0] min_val;
   logic            div_zero;
   logic            overflow;
   logic [XLEN-1:0] special_data;

   always_comb begin
      in_signed    = ~req_op[0];
      a_prep       = req_a;
      b_prep       = req_b;
      if (req_word) begin
         if (in_signed) begin
            a_prep = sext_half(req_a);
            b_prep = sext_half(req_b);
         end else begin
            a_prep = XLEN'(req_a[HALF-1:0]);
            b_prep = XLEN'(req_b[HALF-1:0]);
         end
      end
      a_neg        = in_signed & a_prep[XLEN-1];
      b_neg        = in_signed & b_prep[XLEN-1];
      a_mag        = a_neg ? neg(a_prep) : a_prep;
      b_mag        = b_neg ? neg(b_prep) : b_prep;
      min_val      = req_word ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}}
                              : {1'b1, {(XLEN-1){1'b0}}};
      div_zero     = (b_prep == '0);
      overflow     = in_signed & (a_prep == min_val) & (b_prep == '1);
      special_data = '0;
      if (div_zero) begin
         // Remainder of x/0 is x; W forms always return a sign-extended word
         special_data = req_op[1] ? (req_word ? sext_half(a_prep) : a_prep) : '1;
      end else if (overflow) begin
         special_data = req_op[1] ? '0 : a_prep;
      end
   end

   // Sign and width fix-up of the Divider's unsigned results
   logic [XLEN-1:0] fix_q;
   logic [XLEN-1:0] fix_r;
   logic [XLEN-1:0] fix_data;

   always_comb begin
      fix_q    = (neg_a ^ neg_b) ? neg(div_quotient) : div_quotient;
      fix_r    = neg_a ? neg(div_remainder) : div_remainder;
      fix_data = op_rem ? fix_r : fix_q;
      if (op_word) begin
         fix_data = sext_half(fix_data);
      end
   end

   // Sequencer FSM with registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         req_ready    <= 1'b1;
         resp_valid   <= 1'b0;
         resp_data    <= '0;
         div_en       <= 1'b0;
         div_dividend <= '0;
         div_divisor  <= '0;
         op_rem       <= 1'b0;
         op_word      <= 1'b0;
         neg_a        <= 1'b0;
         neg_b        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready && !flush) begin
                  op_rem       <= req_op[1];
                  op_word      <= req_word;
                  neg_a        <= a_neg;
                  neg_b        <= b_neg;
                  div_dividend <= a_mag;
                  div_divisor  <= b_mag;
                  req_ready    <= 1'b0;
                  if (div_zero || overflow) begin
                     resp_data  <= special_data;
                     resp_valid <= 1'b1;
                     state      <= RESP;
                  end else begin
                     div_en <= 1'b1;
                     state  <= START;
                  end
               end
            end
            START: begin
               div_en <= 1'b0;
               if (flush) begin
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (flush) begin
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end else if (div_compl) begin
                  resp_data  <= fix_data;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end
            end
            RESP: begin
               // Flush beats a simultaneous resp_ready; both release the slot
               if (flush || resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer with a behavioural 64-bit restoring
// Divider attached and a plain-arithmetic RISC-V reference model.
module tb_div_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic        req_word;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic        flush;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_data;
   logic        div_en;
   logic [63:0] div_dividend;
   logic [63:0] div_divisor;
   logic [63:0] div_quotient;
   logic [63:0] div_remainder;
   logic        div_compl;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   div_sequencer #(.XLEN(64)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_op        (req_op),
      .req_word      (req_word),
      .req_a         (req_a),
      .req_b         (req_b),
      .flush         (flush),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_data     (resp_data),
      .div_en        (div_en),
      .div_dividend  (div_dividend),
      .div_divisor   (div_divisor),
      .div_quotient  (div_quotient),
      .div_remainder (div_remainder),
      .div_compl     (div_compl)
   );

   // Behavioural Divider: no reset, 64 restoring steps after the en edge,
   // reading the live dividend bit on every step.
   logic [63:0] m_q = '0;
   logic [63:0] m_r = '0;
   int          m_cnt = 0;
   logic        m_compl = 1'b1;

   function automatic logic [127:0] div_step(input logic [63:0] q, input logic [63:0] r,
                                             input logic [63:0] d, input logic b);
      logic [64:0] t;
      t = {r, b};
      if (t >= {1'b0, d}) begin
         t = t - {1'b0, d};
         return {q[62:0], 1'b1, t[63:0]};
      end
      return {q[62:0], 1'b0, t[63:0]};
   endfunction

   always @(posedge clk) begin
      if (div_en) begin
         m_cnt   <= 64;
         m_compl <= 1'b0;
         m_q     <= '0;
         m_r     <= '0;
      end else if (m_cnt > 0) begin
         {m_q, m_r} <= div_step(m_q, m_r, div_divisor, div_dividend[m_cnt-1]);
         m_cnt      <= m_cnt - 1;
         if (m_cnt == 1) m_compl <= 1'b1;
      end
   end

   assign div_quotient  = m_q;
   assign div_remainder = m_r;
   assign div_compl     = m_compl;

   // Reference: RISC-V M semantics with native arithmetic. Returns {special, result}.
   function automatic logic [64:0] ref_model(input logic [1:0] op, input logic word,
                                             input logic [63:0] a, input logic [63:0] b);
      logic        uns;
      logic        rem;
      logic        sp;
      logic [31:0] a32, b32, q32, r32, res32;
      logic [63:0] q64, r64;
      uns = op[0];
      rem = op[1];
      sp  = 1'b0;
      if (word) begin
         a32 = a[31:0];
         b32 = b[31:0];
         if (b32 == 32'd0) begin
            q32 = 32'hFFFF_FFFF; r32 = a32; sp = 1'b1;
         end else if (!uns && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
            q32 = a32; r32 = 32'd0; sp = 1'b1;
         end else if (uns) begin
            q32 = a32 / b32; r32 = a32 % b32;
         end else begin
            q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
         end
         res32 = rem ? r32 : q32;
         return {sp, {{32{res32[31]}}, res32}};
      end
      if (b == 64'd0) begin
         q64 = '1; r64 = a; sp = 1'b1;
      end else if (!uns && a == 64'h8000_0000_0000_0000 && b == '1) begin
         q64 = a; r64 = '0; sp = 1'b1;
      end else if (uns) begin
         q64 = a / b; r64 = a % b;
      end else begin
         q64 = $signed(a) / $signed(b); r64 = $signed(a) % $signed(b);
      end
      return {sp, rem ? r64 : q64};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%016h expected=0x%016h", name, act, exp);
      end
   endtask

   // One full request: accept, track div_en, measure latency, check data, take response.
   task automatic do_req(input string tag, input logic [1:0] op, input logic word,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input bit special);
      int cyc;
      int en_cnt;
      int en_cyc;
      @(posedge clk); #1;
      chk({tag, "_ready_idle"}, 64'(req_ready), 64'd1);
      req_op = op; req_word = word; req_a = a; req_b = b; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_a = '0; req_b = '0;
      chk({tag, "_ready_busy"}, 64'(req_ready), 64'd0);
      cyc = 1; en_cnt = 0; en_cyc = -1;
      while (resp_valid !== 1'b1 && cyc < 200) begin
         if (div_en) begin en_cnt++; en_cyc = cyc; end
         @(posedge clk); #1;
         cyc++;
      end
      if (div_en) en_cnt++;
      chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd1);
      chk({tag, "_latency"}, 64'(cyc), special ? 64'd1 : 64'd67);
      chk({tag, "_data"}, resp_data, exp);
      chk({tag, "_en_pulses"}, 64'(en_cnt), special ? 64'd0 : 64'd1);
      if (!special) chk({tag, "_en_cycle"}, 64'(en_cyc), 64'd1);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk({tag, "_ready_after"}, 64'(req_ready), 64'd1);
   endtask

   typedef struct {
      logic [1:0]  op;
      logic        word;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      bit          special;
   } vec_t;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   vec_t vecs[13];

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [64:0] r;
      logic [1:0]  op;
      logic        word;
      logic [63:0] a, b, held;
      int          sel, bad;

      vecs[0]  = '{OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 1'b0};
      vecs[1]  = '{OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 1'b0};
      vecs[2]  = '{OP_DIV,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
      vecs[3]  = '{OP_REM,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
      vecs[4]  = '{OP_REM,  1'b0, 64'd7, -64'sd2, 64'd1, 1'b0};
      vecs[5]  = '{OP_DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
      vecs[6]  = '{OP_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 1'b1};
      vecs[7]  = '{OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                   64'h8000_0000_0000_0000, 1'b1};
      vecs[8]  = '{OP_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1};
      vecs[9]  = '{OP_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                   64'hFFFF_FFFF_8000_0000, 1'b1};
      vecs[10] = '{OP_DIVU, 1'b1, 64'h1234_5678_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
      vecs[11] = '{OP_REM,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
      vecs[12] = '{OP_REMU, 1'b1, 64'hABCD_0000_8000_0005, 64'hFFFF_FFFF_0000_0000,
                   64'hFFFF_FFFF_8000_0005, 1'b1};

      reset = 1'b1; req_valid = 1'b0; req_op = '0; req_word = 1'b0;
      req_a = '0; req_b = '0; flush = 1'b0; resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 64'(req_ready), 64'd1);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_data", resp_data, 64'd0);
      chk("rst_div_en", 64'(div_en), 64'd0);
      chk("rst_dividend", div_dividend, 64'd0);
      reset = 1'b0;

      // Directed table
      for (int i = 0; i < 13; i++) begin
         do_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b,
                vecs[i].exp, vecs[i].special);
      end

      // Randomised requests against the reference model
      for (int i = 0; i < 60; i++) begin
         op   = 2'($urandom_range(0, 3));
         word = 1'($urandom_range(0, 1));
         a    = {$urandom, $urandom};
         b    = {$urandom, $urandom};
         sel  = $urandom_range(0, 9);
         case (sel)
            0: b = '0;
            1: begin b = '1; a = word ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000; end
            2: b = 64'($urandom_range(1, 15));
            3: b = 64'(0) - 64'($urandom_range(1, 15));
            4: a = 64'($urandom_range(0, 1000));
            default: ;
         endcase
         r = ref_model(op, word, a, b);
         do_req($sformatf("rnd%0d", i), op, word, a, b, r[63:0], r[64]);
      end

      // Response held under back-pressure
      @(posedge clk); #1;
      req_op = OP_DIVU; req_word = 1'b0; req_a = 64'd1000; req_b = 64'd10; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 0; c < 200 && resp_valid !== 1'b1; c++) begin
         @(posedge clk); #1;
      end
      chk("hold_valid", 64'(resp_valid), 64'd1);
      held = resp_data;
      chk("hold_data", held, 64'd100);
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (resp_valid !== 1'b1 || resp_data !== held) bad++;
      end
      chk("hold_stable", 64'(bad), 64'd0);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk("hold_released", 64'(resp_valid), 64'd0);

      // Flush in IDLE suppresses acceptance
      req_op = OP_DIVU; req_word = 1'b0; req_a = 64'd5; req_b = 64'd0;
      req_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; flush = 1'b0;
      chk("idle_flush_ready", 64'(req_ready), 64'd1);
      chk("idle_flush_valid", 64'(resp_valid), 64'd0);

      // Flush and resp_ready together in RESP: flush wins, slot released
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rflush_valid", 64'(resp_valid), 64'd1);
      flush = 1'b1; resp_ready = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; resp_ready = 1'b0;
      chk("rflush_dropped", 64'(resp_valid), 64'd0);
      chk("rflush_ready", 64'(req_ready), 64'd1);

      // Flush in the middle of WAIT
      req_op = OP_DIV; req_a = 64'd1000; req_b = 64'd7; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (30) begin @(posedge clk); #1; end
      chk("wflush_busy", 64'(req_ready), 64'd0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("wflush_idle", 64'(req_ready), 64'd1);
      bad = 0;
      for (int c = 0; c < 60; c++) begin
         if (resp_valid !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      chk("wflush_no_resp", 64'(bad), 64'd0);
      do_req("post_flush", OP_DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 1'b0);

      // Asynchronous reset in the middle of WAIT
      @(posedge clk); #1;
      req_op = OP_DIVU; req_a = 64'd12345; req_b = 64'd11; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (20) begin @(posedge clk); #1; end
      reset = 1'b1;
      #1;
      chk("mrst_resp_valid", 64'(resp_valid), 64'd0);
      chk("mrst_resp_data", resp_data, 64'd0);
      chk("mrst_div_en", 64'(div_en), 64'd0);
      chk("mrst_dividend", div_dividend, 64'd0);
      chk("mrst_divisor", div_divisor, 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("mrst_ready", 64'(req_ready), 64'd1);
      do_req("post_reset", OP_DIVU, 1'b0, 64'd12345, 64'd11, 64'd1122, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
